// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the 8-bit OoO CPU: holds the CPU in reset,
// releases it, waits for hlt and captures the halted PC and cycle count.
module cpu_run_ctrl #(
    parameter int PC_W       = 8,
    parameter int CYC_W      = 16,
    parameter int RST_CYCLES = 3,
    parameter int SETTLE     = 1,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             cpu_rst_n,
    input  logic             cpu_hlt,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [PC_W-1:0]  halt_pc,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CYC_W-1:0] CYC_MAX     = '1;
    localparam logic [CYC_W-1:0] TO_LAST     = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] TO_COUNT    = CYC_W'(TIMEOUT);
    localparam bit               WD_EN       = (TIMEOUT != 0);
    localparam bit               NO_SETTLE   = (SETTLE == 0);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CYC_W-1:0] cyc_d;
    logic [PC_W-1:0]  pc_d;
    logic             to_d;
    logic             busy_d;
    logic             done_d;
    logic             rst_n_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cyc_d   = cycle_count;
        pc_d    = halt_pc;
        to_d    = timed_out;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    cyc_d   = '0;
                    pc_d    = '0;
                    to_d    = 1'b0;
                end
            end
            S_RESET: begin
                if (cnt == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RUN: begin
                // hlt outranks the watchdog when both land on one edge
                if (cpu_hlt) begin
                    if (NO_SETTLE) begin
                        pc_d    = cpu_pc;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end else if (WD_EN && cycle_count == TO_LAST) begin
                    cyc_d   = TO_COUNT;
                    pc_d    = cpu_pc;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cycle_count != CYC_MAX) begin
                    cyc_d = cycle_count + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    pc_d    = cpu_pc;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d == S_RESET) || (state_d == S_RUN) ||
                  (state_d == S_SETTLE);
        done_d  = (state_d == S_DONE);
        // a timed-out CPU is parked back in reset
        rst_n_d = (state_d == S_RUN) || (state_d == S_SETTLE) ||
                  (done_d && !to_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cpu_rst_n   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cpu_rst_n   <= rst_n_d;
            busy        <= busy_d;
            done        <= done_d;
            timed_out   <= to_d;
            halt_pc     <= pc_d;
            cycle_count <= cyc_d;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (SETTLE=1 and SETTLE=0) share one
// CPU stub; each run's outcome is predicted from the run's hlt schedule.
module tb_cpu_run_ctrl;

    localparam int PC_W = 8;
    localparam int CYC_W = 16;
    localparam int RSTC = 3;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_hlt;
    logic [PC_W-1:0] cpu_pc;

    logic rn1, bz1, dn1, to1;
    logic [PC_W-1:0] pc1;
    logic [CYC_W-1:0] cc1;
    logic rn0, bz0, dn0, to0;
    logic [PC_W-1:0] pc0;
    logic [CYC_W-1:0] cc0;

    int vectors = 0;
    int miscompares = 0;

    // expected state per instance: [1] SETTLE=1, [0] SETTLE=0
    bit e_rn[2], e_bz[2], e_dn[2], e_to[2];
    logic [PC_W-1:0] e_pc[2];
    int e_cc[2];

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .PC_W(PC_W), .CYC_W(CYC_W), .RST_CYCLES(RSTC),
        .SETTLE(1), .TIMEOUT(TO)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .cpu_rst_n(rn1), .cpu_hlt(cpu_hlt), .cpu_pc(cpu_pc),
        .busy(bz1), .done(dn1), .timed_out(to1),
        .halt_pc(pc1), .cycle_count(cc1)
    );

    cpu_run_ctrl #(
        .PC_W(PC_W), .CYC_W(CYC_W), .RST_CYCLES(RSTC),
        .SETTLE(0), .TIMEOUT(TO)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .cpu_rst_n(rn0), .cpu_hlt(cpu_hlt), .cpu_pc(cpu_pc),
        .busy(bz0), .done(dn0), .timed_out(to0),
        .halt_pc(pc0), .cycle_count(cc0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string t, input int i,
                           input logic o_rn, input logic o_bz,
                           input logic o_dn, input logic o_to,
                           input logic [PC_W-1:0] o_pc,
                           input logic [CYC_W-1:0] o_cc);
        chk({t, ".cpu_rst_n"}, 32'(o_rn), 32'(e_rn[i]));
        chk({t, ".busy"}, 32'(o_bz), 32'(e_bz[i]));
        chk({t, ".done"}, 32'(o_dn), 32'(e_dn[i]));
        chk({t, ".timed_out"}, 32'(o_to), 32'(e_to[i]));
        chk({t, ".halt_pc"}, 32'(o_pc), 32'(e_pc[i]));
        chk({t, ".cycle_count"}, 32'(o_cc), 32'(e_cc[i]));
    endtask

    task automatic check_both(input string t);
        chk_dut({t, "/s1"}, 1, rn1, bz1, dn1, to1, pc1, cc1);
        chk_dut({t, "/s0"}, 0, rn0, bz0, dn0, to0, pc0, cc0);
    endtask

    task automatic expect_idle();
        for (int i = 0; i < 2; i++) begin
            e_rn[i] = 0; e_bz[i] = 0; e_dn[i] = 0; e_to[i] = 0;
            e_pc[i] = '0; e_cc[i] = 0;
        end
    endtask

    // Start a run; the CPU stub keeps hlt low for n RUN edges, then raises it.
    task automatic run(input int n, input bit inj);
        logic [PC_W-1:0] p;
        bit halted;
        halted = 0;
        start = 1'b1;
        cpu_hlt = 1'($urandom);
        cpu_pc = PC_W'($urandom);
        tick();
        for (int i = 0; i < 2; i++) begin
            e_bz[i] = 1; e_dn[i] = 0; e_to[i] = 0;
            e_pc[i] = '0; e_cc[i] = 0; e_rn[i] = 0;
        end
        check_both("start");
        for (int r = 1; r <= RSTC; r++) begin
            start = inj ? 1'($urandom) : 1'b0;
            cpu_hlt = 1'($urandom);
            cpu_pc = PC_W'($urandom);
            tick();
            e_rn[0] = (r == RSTC);
            e_rn[1] = (r == RSTC);
            check_both("reset");
        end
        for (int j = 1; j <= n + 1 && j <= TO; j++) begin
            p = PC_W'($urandom);
            cpu_hlt = (j == n + 1);
            cpu_pc = p;
            start = inj ? 1'($urandom) : 1'b0;
            tick();
            if (j == n + 1) begin
                halted = 1;
                e_cc[0] = n; e_cc[1] = n;
                e_dn[0] = 1; e_bz[0] = 0; e_pc[0] = p;
                check_both("halt");
            end else if (j == TO) begin
                for (int i = 0; i < 2; i++) begin
                    e_dn[i] = 1; e_bz[i] = 0; e_to[i] = 1;
                    e_cc[i] = TO; e_pc[i] = p; e_rn[i] = 0;
                end
                check_both("timeout");
            end else begin
                e_cc[0] = j; e_cc[1] = j;
                check_both("run");
            end
        end
        start = 1'b0;
        if (halted) begin
            p = p ^ 8'h03;
            cpu_pc = p;
            cpu_hlt = 1'($urandom);
            tick();
            e_dn[1] = 1; e_bz[1] = 0; e_pc[1] = p;
            check_both("settle");
        end
        for (int k = 0; k < 3; k++) begin
            cpu_pc = PC_W'($urandom);
            cpu_hlt = 1'($urandom);
            tick();
            check_both("frozen");
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cpu_hlt = 1'b0;
        cpu_pc = '0;
        expect_idle();
        tick();
        tick();
        check_both("por");
        rst = 1'b0;
        tick();
        check_both("idle");

        cpu_hlt = 1'b0;
        run(10, 0);
        run(TO - 1, 1);
        run(TO + 5, 1);
        run(0, 0);
        run(TO - 2, 0);
        for (int t = 0; t < 6; t++) begin
            run(int'($urandom_range(0, TO + 4)), 1'($urandom));
        end

        // reset in the middle of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        cpu_hlt = 1'b0;
        for (int k = 0; k < RSTC + 4; k++) tick();
        rst = 1'b1;
        tick();
        expect_idle();
        check_both("midrst");
        rst = 1'b0;
        cpu_hlt = 1'b1;
        tick();
        check_both("midrst_idle");

        run(5, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
